eeprom_loader: RTL and testbench

Boot-time configuration loader that sits directly upstream of the byte-wide EEPROM reader. On a start pulse it walks a contiguous address range, issuing one single-byte read at a time through the reader's `read`/`data_ready` handshake. Each returned byte is presented as an indexed byte stream to downstream configuration registers. It guards every byte with a timeout and, optionally, checks an 8-bit additive checksum over the block.

---
 rtl/eeprom_loader.sv | 107 ++++++++++
 tb/tb_eeprom_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_loader.sv
// eeprom_loader: boot-time loader streaming a contiguous EEPROM byte range with per-byte timeout.
// Define EEPROM_LOADER_CHECKSUM_EN to check an 8-bit additive checksum over the block.
module eeprom_loader #(
  parameter int          NUM_BYTES      = 16,
  parameter logic [10:0] BASE_ADDR      = 11'h000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        checksum_ok,
  output logic [10:0] eeprom_addr,
  output logic        eeprom_read,
  input  logic [7:0]  eeprom_data,
  input  logic        eeprom_data_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [7:0]  byte_index
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FINISH} state_t;
  state_t state, state_nx;
  logic [7:0] index;
  logic [23:0] timer;
  logic last;
  assign last = index == 8'(NUM_BYTES - 1);
`ifdef EEPROM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic sum_ok;
  assign sum_ok = sum == 8'h00;
`else
  logic sum_ok;
  assign sum_ok = 1'b1;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? REQ : IDLE;
      REQ:     state_nx = WAIT;
      WAIT:    state_nx = eeprom_data_ready ? (last ? FINISH : REQ) : (timer == 24'd0 ? FINISH : WAIT);
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      checksum_ok <= 1'b0;
      eeprom_addr <= 11'h000;
      eeprom_read <= 1'b0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      byte_index  <= 8'h00;
      index       <= 8'h00;
      timer       <= 24'd0;
`ifdef EEPROM_LOADER_CHECKSUM_EN
      sum         <= 8'h00;
`endif
    end else begin
      eeprom_read <= state == REQ;
      byte_valid  <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: if (start) begin
          eeprom_addr <= BASE_ADDR;
          index       <= 8'h00;
          error       <= 1'b0;
          checksum_ok <= 1'b0;
          busy        <= 1'b1;
`ifdef EEPROM_LOADER_CHECKSUM_EN
          sum         <= 8'h00;
`endif
        end
        REQ: timer <= 24'(TIMEOUT_CYCLES);
        WAIT: if (eeprom_data_ready) begin
          byte_data  <= eeprom_data;
          byte_index <= index;
          byte_valid <= 1'b1;
`ifdef EEPROM_LOADER_CHECKSUM_EN
          sum        <= sum + eeprom_data;
`endif
          if (!last) begin
            index       <= index + 8'd1;
            eeprom_addr <= eeprom_addr + 11'd1;
          end
        end else if (timer == 24'd0) begin
          error <= 1'b1;
        end else begin
          timer <= timer - 24'd1;
        end
        FINISH: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          checksum_ok <= sum_ok && !error;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_eeprom_loader.sv
// tb_eeprom_loader: table-driven loads against a reader model, plus start/late-ready/reset sequences.
module tb_eeprom_loader;
  localparam int NB = 4;
  localparam int TO = 100;
`ifdef EEPROM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef struct {
    logic [3:0][7:0] d;
    int   lat;
    int   drop;
    logic exp_err;
    logic exp_ck;
    int   exp_strobes;
  } vec_t;

  logic clk = 0, rst = 1, start = 0;
  logic [7:0] eeprom_data = 0;
  logic eeprom_data_ready = 0;
  logic busy, done, error, checksum_ok, eeprom_read, byte_valid;
  logic [10:0] eeprom_addr;
  logic [7:0] byte_data, byte_index;
  logic w_busy, w_done, w_error, w_checksum_ok, w_eeprom_read, w_byte_valid;
  logic [10:0] w_eeprom_addr;
  logic [7:0] w_byte_data, w_byte_index;

  eeprom_loader #(.NUM_BYTES(NB), .BASE_ADDR(11'h010), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .checksum_ok(checksum_ok), .eeprom_addr(eeprom_addr), .eeprom_read(eeprom_read),
    .eeprom_data(eeprom_data), .eeprom_data_ready(eeprom_data_ready),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_index(byte_index));

  eeprom_loader #(.NUM_BYTES(NB), .BASE_ADDR(11'h7FE), .TIMEOUT_CYCLES(TO)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .busy(w_busy), .done(w_done), .error(w_error),
    .checksum_ok(w_checksum_ok), .eeprom_addr(w_eeprom_addr), .eeprom_read(w_eeprom_read),
    .eeprom_data(eeprom_data), .eeprom_data_ready(eeprom_data_ready),
    .byte_valid(w_byte_valid), .byte_data(w_byte_data), .byte_index(w_byte_index));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [3:0][7:0] rdata;
  int rlat = 0, drop = -1, rq = 0, rk = 0, sc = 0, dc = 0;
  int err_cyc = -1, done_cyc = 0;
  int read_cyc[8];
  logic [10:0] ra;
  logic [10:0] addr_log[8], waddr_log[8];
  logic d_err, d_ck;

  // Reader model: answers each read after rlat cycles unless that request is dropped.
  initial forever begin
    @(negedge clk);
    if (eeprom_read && rst) begin
      ra = eeprom_addr;
      rk = rq;
      if (rq < 8) begin
        addr_log[rq] = eeprom_addr;
        waddr_log[rq] = w_eeprom_addr;
        read_cyc[rq] = cyc;
      end
      rq++;
      chk("wrap_read_sync", 32'(w_eeprom_read), 32'd1);
      if (rk != drop) begin
        for (int i = 0; i < rlat; i++) begin
          @(negedge clk);
          if (rst) chk("addr_stable", 32'(eeprom_addr), 32'(ra));
        end
        if (rst) begin
          eeprom_data = rdata[rk[1:0]];
          eeprom_data_ready = 1;
          @(negedge clk);
          eeprom_data_ready = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (byte_valid) begin
      chk("strobe_index", 32'(byte_index), sc);
      chk("strobe_data", 32'(byte_data), 32'(rdata[sc[1:0]]));
      sc++;
    end
    if (done) begin
      dc++;
      done_cyc = cyc;
      d_err = error;
      d_ck = checksum_ok;
    end
    if (error && err_cyc < 0) err_cyc = cyc;
  end

  task automatic arm(input vec_t v);
    rdata = v.d;
    rlat = v.lat;
    drop = v.drop;
    rq = 0;
    sc = 0;
    dc = 0;
    err_cyc = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic run_load(input vec_t v);
    arm(v);
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 2000 && dc == 0; i++) @(negedge clk);
    chk("done_count", dc, 32'd1);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("error", 32'(d_err), 32'(v.exp_err));
    chk("checksum_ok", 32'(d_ck), 32'(v.exp_ck));
    chk("strobes", sc, v.exp_strobes);
    chk("reads", rq, v.drop >= 0 ? v.drop + 1 : NB);
    for (int i = 0; i < rq && i < 8; i++) begin
      chk("addr", 32'(addr_log[i]), 32'(11'h010) + 32'(i));
      chk("wrap_addr", 32'(waddr_log[i]), 32'(11'(32'h7FE + i)));
    end
    if (v.drop >= 0) begin
      chk("timeout_latency", err_cyc - read_cyc[v.drop], TO + 1);
      chk("done_after_error", done_cyc - err_cyc, 32'd1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_checksum_ok"}, 32'(checksum_ok), 0);
    chk({tag, "_addr"}, 32'(eeprom_addr), 0);
    chk({tag, "_read"}, 32'(eeprom_read), 0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 0);
    chk({tag, "_byte_data"}, 32'(byte_data), 0);
    chk({tag, "_byte_index"}, 32'(byte_index), 0);
  endtask

  vec_t vecs[4];
  int sc0, dc0;

  initial begin
    vecs[0] = '{{8'h9A, 8'h33, 8'h22, 8'h11}, 0, -1, 1'b0, 1'b1, 4};
    vecs[1] = '{{8'h9B, 8'h33, 8'h22, 8'h11}, 3, -1, 1'b0, !CK, 4};
    vecs[2] = '{{8'h80, 8'h80, 8'hFF, 8'h01}, 1, -1, 1'b0, 1'b1, 4};
    vecs[3] = '{{8'h44, 8'h33, 8'h22, 8'h11}, 2, 2, 1'b1, 1'b0, 2};
    #1 rst = 0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) run_load(vecs[i]);
    sc0 = sc;
    dc0 = dc;
    @(negedge clk);
    eeprom_data = 8'h5A;
    eeprom_data_ready = 1;
    @(negedge clk);
    eeprom_data_ready = 0;
    repeat (3) @(negedge clk);
    chk("late_ready_strobes", sc, sc0);
    chk("late_ready_done", dc, dc0);
    chk("late_ready_busy", 32'(busy), 0);
    arm('{{8'h9A, 8'h33, 8'h22, 8'h11}, 5, -1, 1'b0, 1'b1, 4});
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 500 && !(byte_valid && byte_index == 8'(NB - 1)); i++) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    repeat (20) @(negedge clk);
    chk("ignored_start_done", dc, 1);
    chk("ignored_start_reads", rq, NB);
    chk("ignored_start_busy", 32'(busy), 0);
    arm('{{8'h9A, 8'h33, 8'h22, 8'h11}, 1, 1, 1'b0, 1'b1, 4});
    pulse_start();
    for (int i = 0; i < 200 && rq < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    rst = 0;
    #1 chk_zero("midread_reset");
    @(negedge clk) rst = 1;
    run_load(vecs[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
